w0rm_multi_timer: RTL

//  Multi-channel programmable interval timer; next generation of the fixed-LOAD/LIMIT static timer.
//  Per channel: runtime load/limit values, one-shot or periodic mode, pause, abort and a sticky IRQ flag.

---
 rtl/w0rm_multi_timer_pkg.sv | 5 +
 rtl/w0rm_timer_channel.sv | 72 +++++++
 rtl/w0rm_timer_defs.vh | 8 +
 rtl/w0rm_multi_timer.sv | 49 ++++
 4 files changed

// File: rtl/w0rm_multi_timer_pkg.sv
// w0rm_multi_timer_pkg: shared constants and channel state type for the multi-channel timer
package w0rm_multi_timer_pkg;
  `include "w0rm_timer_defs.vh"
  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} ch_state_e;
endpackage

// File: rtl/w0rm_timer_channel.sv
// w0rm_timer_channel: one load/limit interval counter with pause, abort and sticky irq
module w0rm_timer_channel
  import w0rm_multi_timer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             pause,
  input  logic             periodic,
  input  logic             irq_ack,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit_val,
  output logic             busy,
  output logic             done,
  output logic             irq,
  output logic             irq_nxt,
  output logic [WIDTH-1:0] count
);
  ch_state_e        state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d, load_q, load_d, limit_q, limit_d;
  logic             per_q, per_d, done_q, done_d, irq_q, irq_d;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load_d  = load_q;
    limit_d = limit_q;
    per_d   = per_q;
    done_d  = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (start) begin
      state_d = ST_RUN;
      cnt_d   = load_val;
      load_d  = load_val;
      limit_d = limit_val;
      per_d   = periodic;
    end else if (state_q == ST_RUN && !pause) begin
      done_d  = cnt_q >= limit_q;
      cnt_d   = !done_d ? cnt_q + 1'b1 : (per_q == MODE_PERIODIC ? load_q : '0);
      state_d = (done_d && per_q != MODE_PERIODIC) ? ST_IDLE : ST_RUN;
    end
    irq_d = done_d | (irq_q & ~irq_ack);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      load_q  <= '0;
      limit_q <= '0;
      per_q   <= MODE_ONESHOT;
      done_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
      limit_q <= limit_d;
      per_q   <= per_d;
      done_q  <= done_d;
      irq_q   <= irq_d;
    end
  end
  assign busy    = state_q == ST_RUN;
  assign done    = done_q;
  assign irq     = irq_q;
  assign irq_nxt = irq_d;
  assign count   = cnt_q;
endmodule

// File: rtl/w0rm_timer_defs.vh
// w0rm_timer_defs: mode encodings and default sizing for the multi-channel timer
`ifndef W0RM_TIMER_DEFS_VH
`define W0RM_TIMER_DEFS_VH
localparam logic MODE_ONESHOT  = 1'b0;
localparam logic MODE_PERIODIC = 1'b1;
localparam int   DEF_WIDTH     = 16;
localparam int   DEF_NUM_CH    = 4;
`endif

// File: rtl/w0rm_multi_timer.sv
// w0rm_multi_timer: NUM_CH independent programmable interval timers with a combined irq flag
module w0rm_multi_timer
  import w0rm_multi_timer_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int WIDTH  = DEF_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       abort,
  input  logic [NUM_CH-1:0]       pause,
  input  logic [NUM_CH-1:0]       periodic,
  input  logic [NUM_CH*WIDTH-1:0] load_val,
  input  logic [NUM_CH*WIDTH-1:0] limit_val,
  input  logic [NUM_CH-1:0]       irq_ack,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       done,
  output logic [NUM_CH-1:0]       irq,
  output logic                    irq_any,
  output logic [NUM_CH*WIDTH-1:0] count
);
  logic [NUM_CH-1:0] irq_nxt;
  logic              irq_any_q, irq_any_d;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    w0rm_timer_channel #(.WIDTH(WIDTH)) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start[i]),
      .abort     (abort[i]),
      .pause     (pause[i]),
      .periodic  (periodic[i]),
      .irq_ack   (irq_ack[i]),
      .load_val  (load_val[i*WIDTH +: WIDTH]),
      .limit_val (limit_val[i*WIDTH +: WIDTH]),
      .busy      (busy[i]),
      .done      (done[i]),
      .irq       (irq[i]),
      .irq_nxt   (irq_nxt[i]),
      .count     (count[i*WIDTH +: WIDTH])
    );
  end
  always_comb irq_any_d = |irq_nxt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_any_q <= 1'b0;
    else        irq_any_q <= irq_any_d;
  end
  assign irq_any = irq_any_q;
endmodule
